// File: rtl/prll_bs_pkg.sv
// prll_bs_pkg: shared types, defaults and destination-mask helper for the parallel bus arbiter
// Contents: state_t FSM encoding, default ID width / broadcast ID, dst_mask() decoder.
package prll_bs_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam int         ID_W_DEF  = 8;
    localparam logic [7:0] BCAST_DEF = 8'hFF;
    // Receiver mask for a header: all-but-source on broadcast, one-hot on a valid ID,
    // all zeros for an out-of-range ID (callers treat zero as "drop").
    function automatic logic [255:0] dst_mask(input int unsigned dst, input int unsigned src,
                                              input int unsigned n, input int unsigned bc);
        logic [255:0] m;
        m = '0;
        for (int unsigned k = 0; k < 256; k++)
            if (k < n) m[k] = (dst == bc) ? (k != src) : (dst == k);
        return m;
    endfunction
endpackage

// File: rtl/prll_bs_rr_pick.sv
// prll_bs_rr_pick: rotating-priority search for the next requester after the last grant
// Ports: req (request vector), last (previous grant index),
//        gnt_idx (winning index), gnt_vld (any request present).
module prll_bs_rr_pick #(
    parameter int drvrs = 4
) (
    input  logic [drvrs-1:0] req,
    input  logic [7:0]       last,
    output logic [7:0]       gnt_idx,
    output logic             gnt_vld
);
    int unsigned       w_base;
    logic [drvrs-1:0]  w_rot;
    // Rotate so the driver after `last` sits at bit 0, then take the lowest set bit.
    always_comb begin
        w_base  = (32'(last) + 32'd1) % drvrs;
        w_rot   = drvrs'({req, req} >> w_base);
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = drvrs - 1; k >= 0; k--)
            if (w_rot[k]) begin
                gnt_idx = 8'((w_base + 32'(k)) % drvrs);
                gnt_vld = 1'b1;
            end
    end
endmodule

// File: rtl/prll_bs_rr_arbtr.sv
// prll_bs_rr_arbtr: N-driver round-robin parallel bus arbiter with header-routed delivery
// Ports: clk/reset (sync, active-high); pndng/pop/D_pop driver FWFT FIFO side;
//        full/push/D_push receiver FIFO side; busy (packet on bus); grant_id (last grant);
//        drop_cnt (invalid-destination count, built only when PRLL_BS_DROP_CNT_EN is defined).
module prll_bs_rr_arbtr
    import prll_bs_pkg::*;
#(
    parameter int              bits      = 32,
    parameter int              drvrs     = 4,
    parameter int              id_w      = ID_W_DEF,
    parameter logic [id_w-1:0] broadcast = BCAST_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [drvrs-1:0]        pndng,
    output logic [drvrs-1:0]        pop,
    input  logic [drvrs*bits-1:0]   D_pop,
    input  logic [drvrs-1:0]        full,
    output logic [drvrs-1:0]        push,
    output logic [drvrs*bits-1:0]   D_push,
    output logic                    busy,
    output logic [7:0]              grant_id,
    output logic [15:0]             drop_cnt
);
    state_t            r_state;
    logic [bits-1:0]   r_bus;
    logic [bits-1:0]   r_dpush;
    logic [7:0]        r_src;
    logic [7:0]        r_grant;
    logic [drvrs-1:0]  r_pop;
    logic [drvrs-1:0]  r_push;
    logic              r_busy;
    logic [7:0]        w_gnt_idx;
    logic              w_gnt_vld;
    logic [bits-1:0]   w_sel;
    logic [drvrs-1:0]  w_oh;
    logic [255:0]      w_mask_all;
    logic [drvrs-1:0]  w_mask;
    logic              w_invalid;

    prll_bs_rr_pick #(.drvrs(drvrs)) u_pick (
        .req     (pndng),
        .last    (r_grant),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    // Constant-index mux keeps the data select and pop one-hot free of variable part-selects.
    always_comb begin
        w_sel = '0;
        w_oh  = '0;
        for (int k = 0; k < drvrs; k++)
            if (w_gnt_idx == 8'(k)) begin
                w_sel   = D_pop[k*bits +: bits];
                w_oh[k] = 1'b1;
            end
    end

    assign w_mask_all = dst_mask(32'(r_bus[bits-1 -: id_w]), 32'(r_src), drvrs, 32'(broadcast));
    assign w_mask     = w_mask_all[drvrs-1:0];
    assign w_invalid  = ~|w_mask_all;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_bus   <= '0;
            r_dpush <= '0;
            r_src   <= '0;
            r_grant <= 8'(drvrs - 1);
            r_pop   <= '0;
            r_push  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_pop  <= '0;
            r_push <= '0;
            case (r_state)
                IDLE: if (w_gnt_vld) begin
                    r_bus   <= w_sel;
                    r_src   <= w_gnt_idx;
                    r_grant <= w_gnt_idx;
                    r_pop   <= w_oh;
                    r_busy  <= 1'b1;
                    r_state <= SEND;
                end
                SEND: if (w_invalid) begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end else if (~|(w_mask & full)) begin
                    // All-or-nothing: every addressed receiver must have room.
                    r_push  <= w_mask;
                    r_dpush <= r_bus;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef PRLL_BS_DROP_CNT_EN
    logic [15:0] r_drop;
    always_ff @(posedge clk) begin
        if (reset) r_drop <= '0;
        else if (r_state == SEND && w_invalid && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
    assign drop_cnt = r_drop;
`else
    assign drop_cnt = '0;
`endif

    assign pop      = r_pop;
    assign push     = r_push;
    assign D_push   = {drvrs{r_dpush}};
    assign busy     = r_busy;
    assign grant_id = r_grant;
endmodule
